// File: rtl/uart_tx_cfg_if.sv
// TX FIFO head/pop handshake plus per-frame format configuration for uart_tx_cfg.
// master = FIFO/config owner, slave = transmitter.
interface uart_tx_cfg_if #(
  parameter int MaxDataLength = 9
);
  logic [MaxDataLength-1:0] tx_fifo_data;
  logic                     tx_fifo_empty;
  logic                     tx_fifo_read_en;
  logic [3:0]               cfg_data_len;
  logic [1:0]               cfg_parity;
  logic                     cfg_stop2;
  logic                     cfg_flow_en;

  modport master (
    output tx_fifo_data,
    output tx_fifo_empty,
    input  tx_fifo_read_en,
    output cfg_data_len,
    output cfg_parity,
    output cfg_stop2,
    output cfg_flow_en
  );

  modport slave (
    input  tx_fifo_data,
    input  tx_fifo_empty,
    output tx_fifo_read_en,
    input  cfg_data_len,
    input  cfg_parity,
    input  cfg_stop2,
    input  cfg_flow_en
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART TX (5..MaxDataLength data, N/O/E parity, 1/2 stop); UART_TX_BREAK_EN adds i_break/BREAK.
// Latency: pop + cfg latch in the launch cycle, start bit on o_tx one clock later; frames can run back-to-back.
// Backpressure: launches only when the FIFO is non-empty and (flow off or i_cts high); CTS is sampled at launch only.
module uart_tx_cfg #(
  parameter int MaxDataLength = 9,
  parameter int OverSample    = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tx,
  input  logic i_cts,
`ifdef UART_TX_BREAK_EN
  input  logic i_break,
`endif
  output logic o_busy,
  output logic o_tx_done,
  uart_tx_cfg_if.slave tx_if
);

  localparam int              CW        = (OverSample > 2) ? $clog2(OverSample) : 1;
  localparam logic [CW-1:0]   CntReload = CW'(OverSample - 1);
  localparam logic [3:0]      LenMin    = 4'd5;
  localparam logic [3:0]      LenMax    = 4'(MaxDataLength);

`ifdef UART_TX_BREAK_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`endif

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [3:0]               bits_q, bits_d;
  logic [MaxDataLength-1:0] shreg_q, shreg_d;
  logic                     par_en_q, par_en_d;
  logic                     par_bit_q, par_bit_d;
  logic                     stop_left_q, stop_left_d;
  logic                     tx_q, tx_d;
  logic                     run_q;
`ifdef UART_TX_BREAK_EN
  logic [3:0]               brk_cnt_q, brk_cnt_d;
  logic                     brk_mark_q, brk_mark_d;
`endif

  logic       launch;
  logic       brk_req;
  logic       bit_end;
  logic       load;
  logic       done_c;
  logic [3:0] len_c;
  logic       par_x;

  // run_q keeps the pop strobe quiet for the first clock after reset release.
  assign launch  = run_q && !tx_if.tx_fifo_empty && (!tx_if.cfg_flow_en || i_cts);
`ifdef UART_TX_BREAK_EN
  assign brk_req = run_q && i_break;
`else
  assign brk_req = 1'b0;
`endif
  assign bit_end = (cnt_q == '0);

  always_comb begin
    len_c = tx_if.cfg_data_len;
    if (tx_if.cfg_data_len < LenMin) begin
      len_c = LenMin;
    end else if (tx_if.cfg_data_len > LenMax) begin
      len_c = LenMax;
    end
  end

  always_comb begin
    par_x = 1'b0;
    for (int i = 0; i < MaxDataLength; i++) begin
      if (4'(i) < len_c) begin
        par_x = par_x ^ tx_if.tx_fifo_data[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = (state_q == IDLE) ? '0 : (bit_end ? CntReload : cnt_q - 1'b1);
    bits_d      = bits_q;
    shreg_d     = shreg_q;
    par_en_d    = par_en_q;
    par_bit_d   = par_bit_q;
    stop_left_d = stop_left_q;
    tx_d        = tx_q;
    load        = 1'b0;
    done_c      = 1'b0;
`ifdef UART_TX_BREAK_EN
    brk_cnt_d   = brk_cnt_q;
    brk_mark_d  = brk_mark_q;
`endif

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (brk_req) begin
`ifdef UART_TX_BREAK_EN
          state_d    = BREAK;
          cnt_d      = CntReload;
          tx_d       = 1'b0;
          brk_cnt_d  = '0;
          brk_mark_d = 1'b0;
`endif
        end else if (launch) begin
          load    = 1'b1;
          state_d = START;
          cnt_d   = CntReload;
          tx_d    = 1'b0;
        end
      end

      START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shreg_q[0];
        end
      end

      DATA: begin
        tx_d = shreg_q[0];
        if (bit_end) begin
          if (bits_q == 4'd0) begin
            state_d = par_en_q ? PARITY : STOP;
            tx_d    = par_en_q ? par_bit_q : 1'b1;
          end else begin
            shreg_d = shreg_q >> 1;
            bits_d  = bits_q - 4'd1;
            tx_d    = shreg_q[1];
          end
        end
      end

      PARITY: begin
        tx_d = par_bit_q;
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end

      STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (stop_left_q) begin
            stop_left_d = 1'b0;
          end else begin
            done_c = 1'b1;
            if (brk_req) begin
`ifdef UART_TX_BREAK_EN
              state_d    = BREAK;
              tx_d       = 1'b0;
              brk_cnt_d  = '0;
              brk_mark_d = 1'b0;
`endif
            end else if (launch) begin
              load    = 1'b1;
              state_d = START;
              tx_d    = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end

`ifdef UART_TX_BREAK_EN
      // Low for at least 12 bit periods, extended a period at a time while i_break holds.
      BREAK: begin
        if (!brk_mark_q) begin
          tx_d = 1'b0;
          if (bit_end) begin
            if (brk_cnt_q != 4'd11) begin
              brk_cnt_d = brk_cnt_q + 4'd1;
            end else if (!i_break) begin
              brk_mark_d = 1'b1;
              tx_d       = 1'b1;
            end
          end
        end else begin
          tx_d = 1'b1;
          if (bit_end) begin
            state_d    = IDLE;
            brk_mark_d = 1'b0;
          end
        end
      end
`endif

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (load) begin
      shreg_d     = tx_if.tx_fifo_data;
      bits_d      = len_c - 4'd1;
      par_en_d    = (tx_if.cfg_parity == 2'b01) || (tx_if.cfg_parity == 2'b10);
      par_bit_d   = (tx_if.cfg_parity == 2'b01) ? ~par_x : par_x;
      stop_left_d = tx_if.cfg_stop2;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bits_q      <= '0;
      shreg_q     <= '0;
      par_en_q    <= 1'b0;
      par_bit_q   <= 1'b0;
      stop_left_q <= 1'b0;
      tx_q        <= 1'b1;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bits_q      <= bits_d;
      shreg_q     <= shreg_d;
      par_en_q    <= par_en_d;
      par_bit_q   <= par_bit_d;
      stop_left_q <= stop_left_d;
      tx_q        <= tx_d;
      run_q       <= 1'b1;
    end
  end

`ifdef UART_TX_BREAK_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      brk_cnt_q  <= '0;
      brk_mark_q <= 1'b0;
    end else begin
      brk_cnt_q  <= brk_cnt_d;
      brk_mark_q <= brk_mark_d;
    end
  end
`endif

  assign o_tx                  = tx_q;
  assign o_busy                = (state_q != IDLE);
  assign o_tx_done             = done_c;
  assign tx_if.tx_fifo_read_en = load;

endmodule
